// File: rtl/instr_sequencer_if.sv
// Fetch / decode / data-memory signal bundle for instr_sequencer.
// master = sequencer side, slave = fetch unit, control_unit and data memory side.
interface instr_sequencer_if;
    logic        fetch_req;
    logic [31:0] pc;
    logic        instr_valid;
    logic [31:0] instruction_in;
    logic [31:0] instruction;
    logic        dec_reg_write_enable;
    logic        dec_mem_load_enable;
    logic        dec_mem_write_enable;
    logic        dec_jump_en;
    logic [31:0] dec_jump_address;
    logic        mem_req;
    logic        mem_we;
    logic        mem_ack;
    logic        reg_write_strobe;
    logic [2:0]  state;
    logic [31:0] instr_retired;

    modport master (
        output fetch_req, pc, instruction, mem_req, mem_we, reg_write_strobe, state, instr_retired,
        input  instr_valid, instruction_in, dec_reg_write_enable, dec_mem_load_enable,
               dec_mem_write_enable, dec_jump_en, dec_jump_address, mem_ack
    );

    modport slave (
        input  fetch_req, pc, instruction, mem_req, mem_we, reg_write_strobe, state, instr_retired,
        output instr_valid, instruction_in, dec_reg_write_enable, dec_mem_load_enable,
               dec_mem_write_enable, dec_jump_en, dec_jump_address, mem_ack
    );
endinterface

// File: rtl/instr_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK instruction sequencer.
// Optional retired-instruction counter enabled by defining PERF_COUNTER_EN.
module instr_sequencer (
    input  logic               clk,
    input  logic               rst,
    instr_sequencer_if.master  bus
);
    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        DECODE    = 3'd1,
        EXECUTE   = 3'd2,
        MEMORY    = 3'd3,
        WRITEBACK = 3'd4
    } state_t;

    state_t      r_state, w_next;
    logic [31:0] r_pc, w_pc_next, w_pc_inc;
    logic [31:0] r_instr;
    logic        w_mem_any;

    assign w_pc_inc  = r_pc + 32'd4;
    assign w_mem_any = bus.dec_mem_load_enable | bus.dec_mem_write_enable;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FETCH;
            r_pc    <= 32'd0;
            r_instr <= 32'd0;
        end else begin
            r_state <= w_next;
            r_pc    <= w_pc_next;
            if (r_state == FETCH && bus.instr_valid)
                r_instr <= bus.instruction_in;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_pc_next = r_pc;
        case (r_state)
            FETCH:   if (bus.instr_valid) w_next = DECODE;
            DECODE:  w_next = EXECUTE;
            EXECUTE: begin
                // jump outranks any memory or register-write enables
                if (bus.dec_jump_en) begin
                    w_pc_next = bus.dec_jump_address & 32'hFFFF_FFFC;
                    w_next    = FETCH;
                end else if (w_mem_any) begin
                    w_next = MEMORY;
                end else if (bus.dec_reg_write_enable) begin
                    w_next = WRITEBACK;
                end else begin
                    w_pc_next = w_pc_inc;
                    w_next    = FETCH;
                end
            end
            MEMORY: begin
                if (bus.mem_ack) begin
                    if (bus.dec_mem_load_enable && bus.dec_reg_write_enable) begin
                        w_next = WRITEBACK;
                    end else begin
                        w_pc_next = w_pc_inc;
                        w_next    = FETCH;
                    end
                end
            end
            WRITEBACK: begin
                w_pc_next = w_pc_inc;
                w_next    = FETCH;
            end
            default: w_next = FETCH;
        endcase
    end

    assign bus.fetch_req        = (r_state == FETCH);
    assign bus.pc               = r_pc;
    assign bus.instruction      = r_instr;
    assign bus.mem_req          = (r_state == MEMORY);
    assign bus.mem_we           = (r_state == MEMORY) && bus.dec_mem_write_enable && !bus.dec_mem_load_enable;
    assign bus.reg_write_strobe = (r_state == WRITEBACK);
    assign bus.state            = r_state;

`ifdef PERF_COUNTER_EN
    logic [31:0] r_retired;
    logic        w_retire;

    assign w_retire = (w_next == FETCH) &&
                      (r_state == EXECUTE || r_state == MEMORY || r_state == WRITEBACK);

    always_ff @(posedge clk) begin
        if (rst)
            r_retired <= 32'd0;
        else if (w_retire)
            r_retired <= r_retired + 32'd1;
    end

    assign bus.instr_retired = r_retired;
`else
    assign bus.instr_retired = 32'd0;
`endif
endmodule

// File: tb/tb_instr_sequencer.sv
// Directed scoreboard bench for instr_sequencer: per-instruction expectations are
// queued when an instruction is issued and compared when it retires back to FETCH.
module tb_instr_sequencer;
    logic clk;
    logic rst;
    instr_sequencer_if bus();

    instr_sequencer dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        int          lat;
        int          mreq;
        int          mwe;
        int          strb;
    } exp_t;

    exp_t        sbq[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] m_pc   = 32'd0;
    int          n_ret  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge with the DUT in FETCH; returns at a negedge back in FETCH.
    task automatic run_instr(input logic [31:0] word, input logic jmp, input logic ld,
                             input logic st, input logic rw, input logic [31:0] jaddr,
                             input int ack_dly);
        exp_t e;
        int   cyc, mcnt, g_mreq, g_mwe, g_strb;
        bit   done;
        e.instr = word; e.mreq = 0; e.mwe = 0; e.strb = 0;
        if (jmp) begin
            e.pc = jaddr & 32'hFFFF_FFFC; e.lat = 3;
        end else if (ld || st) begin
            e.mreq = ack_dly + 1;
            e.mwe  = (st && !ld) ? e.mreq : 0;
            e.strb = (ld && rw) ? 1 : 0;
            e.lat  = 4 + ack_dly + e.strb;
            e.pc   = m_pc + 32'd4;
        end else if (rw) begin
            e.strb = 1; e.lat = 4; e.pc = m_pc + 32'd4;
        end else begin
            e.lat = 3; e.pc = m_pc + 32'd4;
        end
        sbq.push_back(e);

        chk("fetch_req_idle", {31'd0, bus.fetch_req}, 32'd1);
        bus.instr_valid          = 1'b1;
        bus.instruction_in       = word;
        bus.dec_jump_en          = jmp;
        bus.dec_mem_load_enable  = ld;
        bus.dec_mem_write_enable = st;
        bus.dec_reg_write_enable = rw;
        bus.dec_jump_address     = jaddr;
        bus.mem_ack              = 1'b0;
        cyc = 0; mcnt = 0; g_mreq = 0; g_mwe = 0; g_strb = 0; done = 0;
        while (!done && cyc < 60) begin
            @(negedge clk);
            cyc++;
            bus.instr_valid = 1'b0;
            if (bus.mem_req)          g_mreq++;
            if (bus.mem_we)           g_mwe++;
            if (bus.reg_write_strobe) g_strb++;
            if (bus.state === 3'd3) begin
                bus.mem_ack = (mcnt == ack_dly);
                mcnt++;
            end else begin
                bus.mem_ack = 1'b0;
            end
            if (bus.state === 3'd0) done = 1;
        end
        e = sbq.pop_front();
        if (!done) begin
            chk("retire_timeout", 32'd0, 32'd1);
        end else begin
            chk("pc",          bus.pc, e.pc);
            chk("latency",     cyc, e.lat);
            chk("mem_req_cyc", g_mreq, e.mreq);
            chk("mem_we_cyc",  g_mwe, e.mwe);
            chk("wr_strobes",  g_strb, e.strb);
            chk("instruction", bus.instruction, e.instr);
            chk("mem_req_post", {31'd0, bus.mem_req}, 32'd0);
        end
        m_pc = e.pc;
        n_ret++;
    endtask

    initial begin
        int n;
        rst = 1'b1;
        bus.instr_valid = 1'b0; bus.instruction_in = 32'd0;
        bus.dec_reg_write_enable = 1'b0; bus.dec_mem_load_enable = 1'b0;
        bus.dec_mem_write_enable = 1'b0; bus.dec_jump_en = 1'b0;
        bus.dec_jump_address = 32'd0; bus.mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_state",   {29'd0, bus.state}, 32'd0);
        chk("rst_pc",      bus.pc, 32'd0);
        chk("rst_instr",   bus.instruction, 32'd0);
        chk("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
        chk("rst_mem_we",  {31'd0, bus.mem_we}, 32'd0);
        chk("rst_strobe",  {31'd0, bus.reg_write_strobe}, 32'd0);
        chk("rst_retired", bus.instr_retired, 32'd0);
        rst = 1'b0;

        // FETCH holds without instr_valid; stray mem_ack is ignored
        bus.mem_ack = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_state", {29'd0, bus.state}, 32'd0);
        chk("idle_pc",    bus.pc, 32'd0);
        bus.mem_ack = 1'b0;

        //        word          jmp   ld    st    rw    jaddr          ack
        run_instr(32'h1111_1111, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0,         0); // ALU
        run_instr(32'h2222_2222, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0103, 0); // jump beats load
        run_instr(32'h3333_3333, 1'b0, 1'b1, 1'b0, 1'b1, 32'd0,         3); // load -> reg
        run_instr(32'h4444_4444, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0,         0); // store, immediate ack
        run_instr(32'h5555_5555, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0,         0); // reg write
        run_instr(32'h6666_6666, 1'b0, 1'b1, 1'b0, 0,    32'd0,         1); // load, no reg write
        run_instr(32'h7777_7777, 1'b0, 1'b1, 1'b1, 1'b1, 32'd0,         2); // load wins over store
        run_instr(32'h8888_8888, 1'b1, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 0); // jump to top, masked
        run_instr(32'h9999_9999, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0,         0); // pc wraps to 0

`ifdef PERF_COUNTER_EN
        chk("retired", bus.instr_retired, n_ret);
`else
        chk("retired", bus.instr_retired, 32'd0);
`endif

        // reset while waiting on mem_ack
        bus.instr_valid = 1'b1; bus.instruction_in = 32'hABCD_0123;
        bus.dec_jump_en = 1'b0; bus.dec_mem_load_enable = 1'b1;
        bus.dec_mem_write_enable = 1'b0; bus.dec_reg_write_enable = 1'b1;
        n = 0;
        while (bus.state !== 3'd3 && n < 10) begin
            @(negedge clk);
            bus.instr_valid = 1'b0;
            n++;
        end
        chk("reach_memory", {29'd0, bus.state}, 32'd3);
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_state",   {29'd0, bus.state}, 32'd0);
        chk("mrst_mem_req", {31'd0, bus.mem_req}, 32'd0);
        chk("mrst_pc",      bus.pc, 32'd0);
        chk("mrst_instr",   bus.instruction, 32'd0);
        chk("mrst_retired", bus.instr_retired, 32'd0);
        rst = 1'b0;
        bus.mem_ack = 1'b1;
        repeat (2) @(negedge clk);
        chk("late_ack_state",   {29'd0, bus.state}, 32'd0);
        chk("late_ack_mem_req", {31'd0, bus.mem_req}, 32'd0);
        chk("late_ack_pc",      bus.pc, 32'd0);
        bus.mem_ack = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port fetch_req  output  1  high while state FETCH.
REQ-004 SHALL have port pc  output  32  instruction fetch address.
REQ-005 SHALL have port instr_valid  input  1  fetched word present on instruction_in.
REQ-006 SHALL have port instruction_in  input  32  fetched instruction word.
REQ-007 SHALL have port instruction  output  32  latched instruction driven to control_unit.
REQ-008 SHALL have ports dec_reg_write_enable, dec_mem_load_enable, dec_mem_write_enable, dec_jump_en  input  1 each  decoded control_unit outputs.
REQ-009 SHALL have port dec_jump_address  input  32  decoded jump target.
REQ-010 SHALL have port mem_req  output  1  data-memory request.
REQ-011 SHALL have port mem_we  output  1  write qualifier, valid with mem_req.
REQ-012 SHALL have port mem_ack  input  1  data-memory completion.
REQ-013 SHALL have port reg_write_strobe  output  1  single-cycle register-file write.
REQ-014 SHALL have port state  output  3  current FSM state encoding.
REQ-015 SHALL have port instr_retired  output  32  retired-instruction count (see Configuration).

Function
REQ-016 SHALL implement states FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4; codes 5-7 SHALL go to FETCH next cycle.
REQ-017 FETCH: SHALL hold until instr_valid=1, then latch instruction_in into instruction and go to DECODE.
REQ-018 DECODE: SHALL last exactly one cycle, then go to EXECUTE; instruction SHALL stay stable DECODE through retirement.
REQ-019 EXECUTE priority: dec_jump_en -> pc<=dec_jump_address with bits[1:0] forced 0, go FETCH; else any mem enable -> MEMORY; else dec_reg_write_enable -> WRITEBACK; else pc<=pc+4, go FETCH.
REQ-020 Jump SHALL take precedence over simultaneous memory or register-write enables; no mem_req, no reg_write_strobe issued.
REQ-021 MEMORY: mem_req SHALL be 1 every cycle until and including the mem_ack cycle; mem_we = dec_mem_write_enable AND NOT dec_mem_load_enable (load wins when both set).
REQ-022 On mem_ack: load with dec_reg_write_enable -> WRITEBACK; otherwise pc<=pc+4, go FETCH; mem_req SHALL be 0 the cycle after ack.
REQ-023 mem_ack outside MEMORY, and instr_valid outside FETCH, SHALL be ignored.
REQ-024 WRITEBACK: reg_write_strobe SHALL be 1 for exactly that one cycle; pc<=pc+4; go FETCH.
REQ-025 pc+4 SHALL wrap modulo 2^32 (0xFFFFFFFC -> 0x00000000).
REQ-026 Minimum latencies: ALU-only 3 cycles after fetch, jump 3, reg-write 4, store 4 + ack wait, load-to-reg 5 + ack wait.

Reset
REQ-027 rst SHALL force state=FETCH, pc=0, instruction=0, mem_req=0, mem_we=0, reg_write_strobe=0, instr_retired=0 at next edge, overriding all other inputs.
REQ-028 rst asserted in MEMORY SHALL drop mem_req the following cycle; a later mem_ack SHALL be ignored.

Configuration
REQ-029 Macro PERF_COUNTER_EN defined: instr_retired SHALL increment by 1 (wrapping) on every transition into FETCH from EXECUTE, MEMORY or WRITEBACK.
REQ-030 PERF_COUNTER_EN undefined: instr_retired SHALL be constant 0 and no counter register SHALL be synthesized.

Verification
REQ-031 Reset then instr_valid=1, all dec_* =0 -> pc 0->4 after 3 cycles, no mem_req, no reg_write_strobe.
REQ-032 dec_jump_en=1, dec_jump_address=0x00000103, dec_mem_load_enable=1 -> pc=0x00000100, mem_req never asserted.
REQ-033 Load with reg write, mem_ack delayed 3 cycles -> mem_req high 4 cycles, mem_we=0, one reg_write_strobe, pc+4.
REQ-034 Store (dec_mem_write_enable=1), mem_ack same cycle as MEMORY entry -> mem_req/mem_we high 1 cycle, no reg_write_strobe.
REQ-035 pc=0xFFFFFFFC ALU instruction -> pc=0x00000000; rst mid-MEMORY -> state=0, mem_req=0 next cycle.
REQ-036 With PERF_COUNTER_EN, 5 mixed instructions -> instr_retired=5; without, instr_retired=0.
